// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  localparam logic [2:0] c_word_sel = 3'b010;

  localparam int c_gnt_core = 0;
  localparam int c_gnt_dma  = 1;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin picker; a tie goes to the requester
//            that did not win last time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_core,
  input  logic       req_dma,
  input  logic       advance,
  output logic [1:0] grant
);

  owner_t r_last_owner;

  always_comb begin
    grant = 2'b00;
    if (req_core && req_dma) begin
      if (r_last_owner == OWN_DMA) grant[c_gnt_core] = 1'b1;
      else                         grant[c_gnt_dma]  = 1'b1;
    end else begin
      grant[c_gnt_core] = req_core;
      grant[c_gnt_dma]  = req_dma;
    end
  end

  // Starting as DMA lets the core take the first tie out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner <= OWN_DMA;
    end else if (advance && (grant != 2'b00)) begin
      r_last_owner <= grant[c_gnt_dma] ? OWN_DMA : OWN_CORE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares the data-memory port between core load/store and a DMA
//            port. Optional counters enabled by DMEM_ARB_PERF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          DATA_W   = 32,
  parameter int          RD_LAT   = 1,
  parameter logic [2:0]  WORD_SEL = c_word_sel
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic [2:0]        core_ls_sel,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_ls_sel,
`ifdef DMEM_ARB_PERF_EN
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_dma_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                 c_cnt_w    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_lat_init = c_cnt_w'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  owner_t              r_owner;
  logic [c_cnt_w-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_ls_sel;
  logic [DATA_W-1:0]   r_core_rdata;
  logic [DATA_W-1:0]   r_dma_rdata;
  logic                r_dma_rvalid;

  logic                w_idle;
  logic                w_done;
  logic                w_core_req;
  logic [1:0]          w_grant;
  logic                w_gnt_core;
  logic                w_gnt_dma;
  logic                w_rd_grant;
  logic                w_core_done;

  assign w_idle      = (r_state == IDLE);
  assign w_done      = (r_state == BUSY) && (r_lat_cnt == '0);
  assign w_core_req  = core_mem_read | core_mem_write;
  assign w_gnt_core  = w_grant[c_gnt_core];
  assign w_gnt_dma   = w_grant[c_gnt_dma];
  // A core asserting read and write together is served as a write.
  assign w_rd_grant  = (w_gnt_core & ~core_mem_write) | (w_gnt_dma & ~dma_we);
  assign w_core_done = w_done && (r_owner == OWN_CORE);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_core (w_idle & w_core_req),
    .req_dma  (w_idle & dma_req),
    .advance  (w_idle),
    .grant    (w_grant)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_rd_grant) w_state_nxt = BUSY;
      BUSY:    if (w_done)     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_ls_sel = 3'b000;
    dma_gnt    = 1'b0;
    core_rdata = r_core_rdata;
    if (w_gnt_core) begin
      mem_write  = core_mem_write;
      mem_read   = ~core_mem_write;
      mem_addr   = core_addr;
      mem_wdata  = core_wdata;
      mem_ls_sel = core_ls_sel;
    end else if (w_gnt_dma) begin
      mem_write  = dma_we;
      mem_read   = ~dma_we;
      mem_addr   = dma_addr;
      mem_wdata  = dma_wdata;
      mem_ls_sel = WORD_SEL;
      dma_gnt    = 1'b1;
    end else if (r_state == BUSY) begin
      mem_addr   = r_addr;
      mem_ls_sel = r_ls_sel;
    end
    // Bypass so the core can write back at the completion edge.
    if (w_core_done) core_rdata = mem_rdata;
    core_stall = w_core_req & ~((w_gnt_core & core_mem_write) | w_core_done);
  end

  assign dma_rvalid = r_dma_rvalid;
  assign dma_rdata  = r_dma_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= OWN_CORE;
      r_lat_cnt    <= '0;
      r_addr       <= '0;
      r_ls_sel     <= 3'b000;
      r_core_rdata <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_dma_rvalid <= w_done && (r_owner == OWN_DMA);
      if (w_rd_grant) begin
        r_owner   <= w_gnt_dma ? OWN_DMA : OWN_CORE;
        r_addr    <= mem_addr;
        r_ls_sel  <= mem_ls_sel;
        r_lat_cnt <= c_lat_init;
      end else if ((r_state == BUSY) && (r_lat_cnt != '0)) begin
        r_lat_cnt <= r_lat_cnt - c_cnt_w'(1);
      end
      if (w_done) begin
        if (r_owner == OWN_CORE) r_core_rdata <= mem_rdata;
        else                     r_dma_rdata  <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_dma_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall_cnt <= '0;
      r_perf_dma_cnt   <= '0;
    end else begin
      if (core_stall) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
      if (dma_gnt)    r_perf_dma_cnt   <= r_perf_dma_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall_cnt;
  assign perf_dma_cnt   = r_perf_dma_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed bench for dmem_arbiter at RD_LAT=1 and RD_LAT=3.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_mem_read, core_mem_write;
  logic [31:0] core_addr, core_wdata;
  logic [2:0]  core_ls_sel;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        core_stall, dma_gnt, dma_rvalid, mem_read, mem_write;
  logic [2:0]  mem_ls_sel;

  logic [31:0] core_rdata_3, dma_rdata_3, mem_addr_3, mem_wdata_3;
  logic        core_stall_3, dma_gnt_3, dma_rvalid_3, mem_read_3, mem_write_3;
  logic [2:0]  mem_ls_sel_3;

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_dma_cnt, perf_stall_cnt_3, perf_dma_cnt_3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ls_sel(core_ls_sel),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ls_sel(mem_ls_sel),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_dma_cnt(perf_dma_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .core_mem_read(core_mem_read), .core_mem_write(core_mem_write),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ls_sel(core_ls_sel),
    .core_rdata(core_rdata_3), .core_stall(core_stall_3),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt_3), .dma_rvalid(dma_rvalid_3), .dma_rdata(dma_rdata_3),
    .mem_read(mem_read_3), .mem_write(mem_write_3), .mem_addr(mem_addr_3),
    .mem_wdata(mem_wdata_3), .mem_ls_sel(mem_ls_sel_3),
`ifdef DMEM_ARB_PERF_EN
    .perf_stall_cnt(perf_stall_cnt_3), .perf_dma_cnt(perf_dma_cnt_3),
`endif
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cyc;
    @(negedge clk);
  endtask

  initial begin
    logic seen;
    int   first;

    reset = 1'b0;
    core_mem_read = 1'b0; core_mem_write = 1'b0;
    core_addr = '0; core_wdata = '0; core_ls_sel = 3'b000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;

    // Reset state
    mid_cyc;
    check("rst_stall", core_stall, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_dma_rvalid", dma_rvalid, 0);
    check("rst_dma_gnt", dma_gnt, 0);

    // Reset during an outstanding DMA read (RD_LAT=3)
    next_cyc; reset = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80; mem_rdata = 32'hAAAA5555;
    mid_cyc;
    check("midrst_gnt3", dma_gnt_3, 1);
    check("midrst_rd3", mem_read_3, 1);
    next_cyc; dma_req = 1'b0; reset = 1'b0;
    mid_cyc;
    check("midrst_addr3", mem_addr_3, 0);
    check("midrst_rvalid3", dma_rvalid_3, 0);
    check("midrst_rdata3", dma_rdata_3, 0);
    next_cyc; reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid_cyc;
      seen = seen | dma_rvalid_3 | dma_rvalid;
      next_cyc;
    end
    check("midrst_no_rvalid", seen, 0);

    // Tie after reset: core read vs DMA write, core first
    core_mem_read = 1'b1; core_addr = 32'h30; core_ls_sel = 3'b010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h11112222;
    mem_rdata = 32'h0BADF00D;
    mid_cyc;
    check("tie_mem_read", mem_read, 1);
    check("tie_mem_addr", mem_addr, 32'h30);
    check("tie_stall", core_stall, 1);
    check("tie_dma_gnt", dma_gnt, 0);
    check("tie_mem_read3", mem_read_3, 1);
    check("tie_dma_gnt3", dma_gnt_3, 0);
    next_cyc;
    mid_cyc;
    check("tie_done_stall", core_stall, 0);
    check("tie_bypass", core_rdata, 32'h0BADF00D);
    check("tie_busy_addr", mem_addr, 32'h30);
    check("tie_busy_rd", mem_read, 0);
    check("tie_busy_gnt", dma_gnt, 0);
    next_cyc; core_mem_read = 1'b0;
    mid_cyc;
    check("tie_dma_gnt2", dma_gnt, 1);
    check("tie_dma_wr", mem_write, 1);
    check("tie_dma_addr", mem_addr, 32'h40);
    check("tie_dma_wdata", mem_wdata, 32'h11112222);
    check("tie_dma_ls", mem_ls_sel, 3'b010);
    check("tie_core_rdata_reg", core_rdata, 32'h0BADF00D);
    next_cyc; core_mem_write = 1'b1; core_addr = 32'h44; core_wdata = 32'h55;
    mid_cyc;
    check("tie2_mem_write", mem_write, 1);
    check("tie2_mem_addr", mem_addr, 32'h44);
    check("tie2_dma_gnt", dma_gnt, 0);
    check("tie2_stall", core_stall, 0);

    // Core store alone, then read+write asserted together
    next_cyc; dma_req = 1'b0;
    core_addr = 32'h10; core_wdata = 32'hDEADBEEF; core_ls_sel = 3'b010;
    mid_cyc;
    check("st_mem_write", mem_write, 1);
    check("st_mem_read", mem_read, 0);
    check("st_mem_addr", mem_addr, 32'h10);
    check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("st_stall", core_stall, 0);
    next_cyc; core_mem_read = 1'b1;
    mid_cyc;
    check("rw_mem_write", mem_write, 1);
    check("rw_mem_read", mem_read, 0);
    check("rw_stall", core_stall, 0);

    // Core load alone
    next_cyc; core_mem_write = 1'b0; core_addr = 32'h20; mem_rdata = 32'h12345678;
    mid_cyc;
    check("ld_stall", core_stall, 1);
    check("ld_mem_read", mem_read, 1);
    check("ld_addr", mem_addr, 32'h20);
    next_cyc;
    mid_cyc;
    check("ld_done_stall", core_stall, 0);
    check("ld_rdata", core_rdata, 32'h12345678);
    next_cyc; core_mem_read = 1'b0; mem_rdata = 32'h0;
    mid_cyc;
    check("ld_rdata_reg", core_rdata, 32'h12345678);
    check("ld_idle_rd", mem_read, 0);

    // Back-to-back DMA reads against continuous core stores
    next_cyc;
    core_mem_write = 1'b1; core_addr = 32'h50; core_wdata = 32'hC0C0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100; mem_rdata = 32'hD0D0D0D0;
    mid_cyc;
    check("b2b_gnt0", dma_gnt, 1);
    check("b2b_rd0", mem_read, 1);
    check("b2b_addr0", mem_addr, 32'h100);
    check("b2b_stall0", core_stall, 1);
    next_cyc; dma_addr = 32'h104;
    mid_cyc;
    check("b2b_busy_stall", core_stall, 1);
    check("b2b_busy_addr", mem_addr, 32'h100);
    check("b2b_busy_gnt", dma_gnt, 0);
    next_cyc; mem_rdata = 32'hD1D1D1D1;
    mid_cyc;
    check("b2b_core_wr", mem_write, 1);
    check("b2b_core_addr", mem_addr, 32'h50);
    check("b2b_core_stall", core_stall, 0);
    check("b2b_core_gnt", dma_gnt, 0);
    check("b2b_rvalid0", dma_rvalid, 1);
    check("b2b_rdata0", dma_rdata, 32'hD0D0D0D0);
    next_cyc; core_addr = 32'h54;
    mid_cyc;
    check("b2b_gnt1", dma_gnt, 1);
    check("b2b_rd1", mem_read, 1);
    check("b2b_addr1", mem_addr, 32'h104);
    check("b2b_stall1", core_stall, 1);
    check("b2b_rvalid_pulse", dma_rvalid, 0);
    next_cyc; dma_req = 1'b0;
    mid_cyc;
    check("b2b_busy1_stall", core_stall, 1);
    next_cyc;
    mid_cyc;
    check("b2b_core_wr2", mem_write, 1);
    check("b2b_core_addr2", mem_addr, 32'h54);
    check("b2b_core_stall2", core_stall, 0);
    check("b2b_rvalid1", dma_rvalid, 1);
    check("b2b_rdata1", dma_rdata, 32'hD1D1D1D1);
    next_cyc; core_mem_write = 1'b0;
    mid_cyc;
    check("b2b_rvalid_end", dma_rvalid, 0);

    // Read latency with RD_LAT=3
    next_cyc; reset = 1'b0;
    next_cyc; reset = 1'b1;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; mem_rdata = 32'h33334444;
    mid_cyc;
    check("lat3_gnt", dma_gnt_3, 1);
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      next_cyc;
      dma_req = 1'b0;
      mid_cyc;
      if (i == 1) check("lat3_busy_addr", mem_addr_3, 32'h200);
      if (dma_rvalid_3 && first == 0) first = i;
    end
    check("lat3_rvalid_cycle", first, 4);
    check("lat3_rdata", dma_rdata_3, 32'h33334444);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
